// File: rtl/bf_weight_loader.sv
// Purpose: SPI-loaded beam weights for 8 elements, double-buffered (shadow/active), swapped on a sample boundary.
// Latency: frame decoded 4 CLOCK cycles after SS rises at the pin; commit loads 1..(strobe period + 1) cycles after WAIT.
// Backpressure: none; frames are accepted at any time and a COMMIT arriving while one is pending merges into it.
module bf_weight_loader #(
    parameter int N_ELEM     = 8,
    parameter int W_WIDTH    = 5,
    parameter int FRAME_BITS = 32
) (
    input  logic                      CLOCK,
    input  logic                      RESET_N,
    input  logic                      SCLK,
    input  logic                      MOSI,
    input  logic                      SS,
    input  logic                      SAMPLE_STROBE,
    output logic [N_ELEM*W_WIDTH-1:0] W_COS_1,
    output logic [N_ELEM*W_WIDTH-1:0] W_SIN_1,
    output logic [N_ELEM*W_WIDTH-1:0] W_COS_2,
    output logic [N_ELEM*W_WIDTH-1:0] W_SIN_2,
    output logic                      CFG_BUSY,
    output logic                      COMMIT_DONE,
    output logic                      FRAME_ERR
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [W_WIDTH-1:0] COS_RST = {1'b0, {(W_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {CMD_NOP, CMD_WRITE, CMD_COMMIT, CMD_CLEAR} cmd_t;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_LOAD} state_t;

    // Banks 0/2 are cos (unity-ish magnitude at reset), banks 1/3 are sin (zero) -> broadside beam.
    function automatic logic [W_WIDTH-1:0] rst_weight(input int b);
        return (b % 2 == 0) ? COS_RST : '0;
    endfunction

    logic [1:0]            sclk_sync, mosi_sync, ss_sync;
    logic                  sclk_prev, ss_prev;
    logic                  sclk_rise, ss_fall, ss_rise;
    logic [FRAME_BITS-1:0] shift_dat;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  frame_vld;
    cmd_t                  cmd;
    logic [1:0]            bank;
    logic [2:0]            idx;
    logic [W_WIDTH-1:0]    weight;
    logic                  idx_ok, wr_en, commit_req;
    logic                  unused_bits;
    logic [W_WIDTH-1:0]    shadow [4][N_ELEM];
    logic [W_WIDTH-1:0]    active [4][N_ELEM];
    state_t                state, state_nxt;

    assign sclk_rise = sclk_sync[1] & ~sclk_prev & ~ss_sync[1];
    assign ss_fall   = ~ss_sync[1] & ss_prev;
    assign ss_rise   = ss_sync[1] & ~ss_prev;

    // The shift register holds still while SS is high, so the frame is decoded straight from it.
    assign cmd         = cmd_t'(shift_dat[31:30]);
    assign bank        = shift_dat[29:28];
    assign idx         = shift_dat[26:24];
    assign weight      = shift_dat[W_WIDTH-1:0];
    assign idx_ok      = ({29'd0, idx} < 32'(N_ELEM));
    assign wr_en       = frame_vld && (cmd == CMD_WRITE) && idx_ok;
    assign commit_req  = frame_vld && (cmd == CMD_COMMIT);
    assign unused_bits = ^{shift_dat[27], shift_dat[23:W_WIDTH]};

    // Two-flop synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ss_sync   <= 2'b11;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            ss_sync   <= {ss_sync[0], SS};
            sclk_prev <= sclk_sync[1];
            ss_prev   <= ss_sync[1];
        end
    end

    // Frame assembly: MSB-first shift, saturating bit count, length check when SS releases.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_dat <= '0;
            bit_cnt   <= '0;
            frame_vld <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            frame_vld <= ss_rise && (bit_cnt == CNT_W'(FRAME_BITS));
            FRAME_ERR <= (ss_rise && (bit_cnt != CNT_W'(FRAME_BITS))) ||
                         (frame_vld && (cmd == CMD_WRITE) && !idx_ok);
            if (ss_fall) begin
                shift_dat <= '0;
                bit_cnt   <= '0;
            end else if (sclk_rise) begin
                shift_dat <= {shift_dat[FRAME_BITS-2:0], mosi_sync[1]};
                if (bit_cnt != CNT_W'(FRAME_BITS + 1))
                    bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Shadow bank: WRITE updates one element, CLEAR restores every shadow element to its reset value.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < N_ELEM; k++)
                    shadow[b][k] <= rst_weight(b);
        end else if (frame_vld && (cmd == CMD_CLEAR)) begin
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < N_ELEM; k++)
                    shadow[b][k] <= rst_weight(b);
        end else if (wr_en) begin
            for (int k = 0; k < N_ELEM; k++)
                if (idx == 3'(k))
                    shadow[bank][k] <= weight;
        end
    end

    // Active bank copies the shadow at the end of LOAD, so a decode in that same cycle is not included.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < N_ELEM; k++)
                    active[b][k] <= rst_weight(b);
        end else if (state == ST_LOAD) begin
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < N_ELEM; k++)
                    active[b][k] <= shadow[b][k];
        end
    end

    // Commit FSM state register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Commit FSM: a strobe in the decode cycle is seen in IDLE and ignored; COMMIT in WAIT merges.
    always_comb begin
        state_nxt   = state;
        CFG_BUSY    = 1'b0;
        COMMIT_DONE = 1'b0;
        case (state)
            ST_IDLE: if (commit_req) state_nxt = ST_WAIT;
            ST_WAIT: begin
                CFG_BUSY = 1'b1;
                if (SAMPLE_STROBE) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                CFG_BUSY    = 1'b1;
                COMMIT_DONE = 1'b1;
                state_nxt   = commit_req ? ST_WAIT : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    for (genvar k = 0; k < N_ELEM; k++) begin : g_out
        assign W_COS_1[k*W_WIDTH +: W_WIDTH] = active[0][k];
        assign W_SIN_1[k*W_WIDTH +: W_WIDTH] = active[1][k];
        assign W_COS_2[k*W_WIDTH +: W_WIDTH] = active[2][k];
        assign W_SIN_2[k*W_WIDTH +: W_WIDTH] = active[3][k];
    end

endmodule

// File: tb/tb_bf_weight_loader.sv
// Purpose: directed bench for bf_weight_loader; a bank/queue-level model is checked against the DUT every cycle.
// Latency: SPI bit period is 8 CLOCK cycles; the model applies each frame once the frame has settled.
// Backpressure: none; strobes are only issued while no frame is in flight.
module tb_bf_weight_loader;

    localparam logic [1:0] C_NOP = 2'b00, C_WR = 2'b01, C_CM = 2'b10, C_CL = 2'b11;
    localparam logic [63:0] JUNK = 64'h0000_0000_0812_34A0;
    localparam logic [159:0] RST_ALL = {40'd0, {8{5'd15}}, 40'd0, {8{5'd15}}};

    logic CLOCK = 1'b0;
    logic RESET_N, SCLK, MOSI, SS, SAMPLE_STROBE;
    logic [39:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic        cfg_busy, commit_done, frame_err;
    logic [29:0] u6_cos_1, u6_sin_1, u6_cos_2, u6_sin_2;
    logic        u6_busy, u6_done, u6_err;

    logic [4:0] m_shadow [4][8];
    logic [4:0] m_active [4][8];
    bit m_pending, settling, strobe_last, run_cmp;
    int checks = 0, failures = 0;
    int done_cnt = 0, err_cnt = 0, err6_cnt = 0;
    int d0;
    logic [31:0] f;

    always #5 CLOCK = ~CLOCK;

    bf_weight_loader #(.N_ELEM(8), .W_WIDTH(5), .FRAME_BITS(32)) u_dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SCLK(SCLK), .MOSI(MOSI), .SS(SS),
        .SAMPLE_STROBE(SAMPLE_STROBE),
        .W_COS_1(w_cos_1), .W_SIN_1(w_sin_1), .W_COS_2(w_cos_2), .W_SIN_2(w_sin_2),
        .CFG_BUSY(cfg_busy), .COMMIT_DONE(commit_done), .FRAME_ERR(frame_err)
    );

    bf_weight_loader #(.N_ELEM(6), .W_WIDTH(5), .FRAME_BITS(32)) u_dut6 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .SCLK(SCLK), .MOSI(MOSI), .SS(SS),
        .SAMPLE_STROBE(SAMPLE_STROBE),
        .W_COS_1(u6_cos_1), .W_SIN_1(u6_sin_1), .W_COS_2(u6_cos_2), .W_SIN_2(u6_sin_2),
        .CFG_BUSY(u6_busy), .COMMIT_DONE(u6_done), .FRAME_ERR(u6_err)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++) begin
                m_shadow[b][k] = (b % 2 == 0) ? 5'd15 : 5'd0;
                m_active[b][k] = (b % 2 == 0) ? 5'd15 : 5'd0;
            end
        m_pending   = 1'b0;
        settling    = 1'b0;
        strobe_last = 1'b0;
    endtask

    function automatic logic [159:0] active_flat();
        logic [159:0] r;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
                r[b*40 + k*5 +: 5] = m_active[b][k];
        return r;
    endfunction

    function automatic logic [63:0] mk(input logic [1:0] cmd, input logic [1:0] bank,
                                       input logic [2:0] idx, input logic [4:0] w);
        return {32'd0, cmd, bank, 1'b0, idx, 19'd0, w};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        MOSI = b;
        cyc(4);
        SCLK = 1'b1;
        cyc(4);
        SCLK = 1'b0;
    endtask

    task automatic strobes(input int n, input int per);
        repeat (n) begin
            SAMPLE_STROBE = 1'b1;
            cyc(1);
            SAMPLE_STROBE = 1'b0;
            cyc(per - 1);
        end
    endtask

    // Sends a frame, then applies its effect to the model once the DUT has had time to decode it.
    task automatic send_frame(input logic [63:0] bits, input int nbits, input string name);
        int e8, e6;
        logic [31:0] w;
        bit x8, x6;
        e8 = err_cnt;
        e6 = err6_cnt;
        SS = 1'b0;
        cyc(8);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(bits[i]);
        cyc(4);
        settling = 1'b1;
        SS = 1'b1;
        cyc(12);
        x8 = 1'b0;
        x6 = 1'b0;
        w  = bits[31:0];
        if (nbits != 32) begin
            x8 = 1'b1;
            x6 = 1'b1;
        end else begin
            case (w[31:30])
                C_WR: begin
                    m_shadow[w[29:28]][w[26:24]] = w[4:0];
                    if (w[26:24] >= 3'd6) x6 = 1'b1;
                end
                C_CM: m_pending = 1'b1;
                C_CL: begin
                    for (int b = 0; b < 4; b++)
                        for (int k = 0; k < 8; k++)
                            m_shadow[b][k] = (b % 2 == 0) ? 5'd15 : 5'd0;
                end
                default: ;
            endcase
        end
        chk({name, "_err8"}, 160'(err_cnt - e8), 160'(x8));
        chk({name, "_err6"}, 160'(err6_cnt - e6), 160'(x6));
        settling = 1'b0;
    endtask

    // Asserts reset off-edge and checks the outputs fall back before any clock edge.
    task automatic reset_mid(input string name);
        #3 RESET_N = 1'b0;
        #2;
        chk({name, "_async_banks"}, {w_sin_2, w_cos_2, w_sin_1, w_cos_1}, RST_ALL);
        chk({name, "_async_busy"}, cfg_busy, 0);
        chk({name, "_async_done"}, commit_done, 0);
        SS = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        SAMPLE_STROBE = 1'b0;
        model_reset();
        cyc(3);
        RESET_N = 1'b1;
        cyc(3);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLOCK) begin
        if (!RESET_N) begin
            strobe_last = 1'b0;
        end else if (run_cmp) begin
            chk("active_banks", {w_sin_2, w_cos_2, w_sin_1, w_cos_1}, active_flat());
            chk("commit_done", commit_done, 160'(m_pending && strobe_last));
            if (!settling) begin
                chk("cfg_busy", cfg_busy, 160'(m_pending));
                chk("frame_err_idle", frame_err, 0);
            end
            if (commit_done) done_cnt++;
            if (m_pending && strobe_last) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            strobe_last = SAMPLE_STROBE;
        end
    end

    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (frame_err) err_cnt++;
            if (u6_err) err6_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0;
        SS = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        SAMPLE_STROBE = 1'b0;
        run_cmp = 1'b0;
        model_reset();
        cyc(4);
        RESET_N = 1'b1;
        cyc(3);
        run_cmp = 1'b1;

        // Reset state
        chk("rst_cos_1", w_cos_1, {8{5'd15}});
        chk("rst_sin_1", w_sin_1, 0);
        chk("rst_cos_2", w_cos_2, {8{5'd15}});
        chk("rst_sin_2", w_sin_2, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_err", frame_err, 0);

        // Single write + commit, junk in ignored bits of the commit frame
        d0 = done_cnt;
        send_frame(mk(C_WR, 2'd1, 3'd2, 5'h14), 32, "t2_write");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0) | JUNK, 32, "t2_commit");
        chk("t2_busy", cfg_busy, 1);
        strobes(3, 16);
        chk("t2_done_once", 160'(done_cnt - d0), 1);
        chk("t2_sin_1", w_sin_1, {25'd0, 5'h14, 10'd0});
        chk("t2_cos_1", w_cos_1, {8{5'd15}});

        // Write without commit stays in shadow across many strobes
        send_frame(mk(C_WR, 2'd0, 3'd5, 5'h0A), 32, "t3_write");
        send_frame(mk(C_NOP, 2'd3, 3'd1, 5'h1F), 32, "t3_nop");
        strobes(100, 16);
        chk("t3_cos_1_held", w_cos_1, {8{5'd15}});
        d0 = done_cnt;
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t3_commit");
        strobes(2, 16);
        chk("t3_done_once", 160'(done_cnt - d0), 1);
        chk("t3_cos_1", w_cos_1, {{2{5'd15}}, 5'h0A, {5{5'd15}}});

        // Short and long frames discarded; top indices and the N_ELEM=6 bound
        send_frame(mk(C_WR, 2'd3, 3'd1, 5'h07), 31, "t4_short");
        send_frame(mk(C_WR, 2'd3, 3'd1, 5'h07), 33, "t4_long");
        send_frame(mk(C_WR, 2'd3, 3'd7, 5'h03), 32, "t4_idx7");
        send_frame(mk(C_WR, 2'd3, 3'd6, 5'h1F), 32, "t4_idx6");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t4_commit");
        strobes(1, 16);
        chk("t4_sin_2", w_sin_2, {5'h03, 5'h1F, 30'd0});

        // Two commits before a strobe merge into one load
        d0 = done_cnt;
        send_frame(mk(C_WR, 2'd1, 3'd3, 5'h05), 32, "t5_write_a");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t5_commit_a");
        send_frame(mk(C_WR, 2'd2, 3'd0, 5'h11), 32, "t5_write_b");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t5_commit_b");
        chk("t5_busy", cfg_busy, 1);
        strobes(2, 16);
        chk("t5_done_once", 160'(done_cnt - d0), 1);
        chk("t5_sin_1", w_sin_1, {20'd0, 5'h05, 5'h14, 10'd0});
        chk("t5_cos_2", w_cos_2, {{7{5'd15}}, 5'h11});

        // CLEAR touches shadow only until committed
        send_frame(mk(C_CL, 2'd0, 3'd0, 5'd0), 32, "t5_clear");
        chk("t5_clear_active_kept", w_sin_2, {5'h03, 5'h1F, 30'd0});
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t5_commit_c");
        strobes(1, 16);
        chk("t5_cleared", {w_sin_2, w_cos_2, w_sin_1, w_cos_1}, RST_ALL);

        // Reset during WAIT
        send_frame(mk(C_WR, 2'd0, 3'd0, 5'h01), 32, "t6_write_a");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t6_commit_a");
        strobes(1, 16);
        chk("t6_cos_1", w_cos_1, {{7{5'd15}}, 5'h01});
        send_frame(mk(C_WR, 2'd0, 3'd1, 5'h02), 32, "t6_write_b");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t6_commit_b");
        chk("t6_busy_wait", cfg_busy, 1);
        reset_mid("t6_wait");
        send_frame(mk(C_WR, 2'd3, 3'd4, 5'h0B), 32, "t6_write_c");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t6_commit_c");
        strobes(1, 16);
        chk("t6_sin_2", w_sin_2, {15'd0, 5'h0B, 20'd0});
        chk("t6_cos_1_after_wait_rst", w_cos_1, {8{5'd15}});

        // Reset at bit 17 of a frame, then a normal frame
        f = mk(C_WR, 2'd0, 3'd0, 5'h1A);
        SS = 1'b0;
        cyc(8);
        for (int i = 31; i >= 15; i--) shift_bit(f[i]);
        reset_mid("t6_midframe");
        d0 = done_cnt;
        send_frame(mk(C_WR, 2'd2, 3'd7, 5'h09), 32, "t6_write_d");
        send_frame(mk(C_CM, 2'd0, 3'd0, 5'd0), 32, "t6_commit_d");
        strobes(1, 16);
        chk("t6_done_once", 160'(done_cnt - d0), 1);
        chk("t6_cos_2", w_cos_2, {5'h09, {7{5'd15}}});
        chk("t6_cos_1_final", w_cos_1, {8{5'd15}});

        cyc(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
